qsn_cyclic_shift_pipe: RTL and testbench

//  Parametrised QSN cyclic shifter for QC-LDPC message passing: rotates Q bit-planes of a Z_MAX-wide

---
 rtl/qsn_pkg.sv | 28 ++
 rtl/qsn_rot_plane.sv | 37 +++
 rtl/qsn_cyclic_shift_pipe.sv | 114 +++++++++++
 tb/tb_qsn_cyclic_shift_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsn_pkg.sv
// Shared defaults, types and helpers for the QSN cyclic shifter.
package qsn_pkg;

    localparam int QSN_Z_MAX = 15;
    localparam int QSN_Q     = 4;
    localparam int QSN_SW    = 4;
    localparam int QSN_TAG_W = 8;

    typedef struct packed {
        logic [QSN_Q*QSN_Z_MAX-1:0] data;
        logic [QSN_TAG_W-1:0]       tag;
        logic                       err;
    } qsn_beat_t;

    // Bit offset of plane b inside a packed Q*z_max vector.
    function automatic int plane_idx(input int b, input int z_max);
        return b * z_max;
    endfunction

    function automatic logic [QSN_Z_MAX-1:0] col_mask(input int n);
        logic [QSN_Z_MAX-1:0] m;
        for (int j = 0; j < QSN_Z_MAX; j++) begin
            m[j] = (j < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/qsn_rot_plane.sv
// One bit-plane of the shifter: splits the active z columns into the part
// that slides down (left) and the part that wraps around (right).
module qsn_rot_plane
    import qsn_pkg::*;
#(
    parameter int Z_MAX = QSN_Z_MAX,
    parameter int SW    = QSN_SW
) (
    input  logic [Z_MAX-1:0] plane_i,
    input  logic [SW-1:0]    shift_i,
    input  logic [SW-1:0]    zlen_i,
    input  logic             kill_i,
    output logic [Z_MAX-1:0] left_o,
    output logic [Z_MAX-1:0] right_o
);

    logic [SW-1:0]    keep;
    logic [Z_MAX-1:0] left_mask;
    logic [Z_MAX-1:0] zone_mask;

    // NOTE: every variable gets a full assignment before the kill override,
    // so this block can never infer a latch.
    always_comb begin
        keep = zlen_i - shift_i;
        for (int j = 0; j < Z_MAX; j++) begin
            left_mask[j] = (j < int'(keep));
            zone_mask[j] = (j < int'(zlen_i));
        end
        left_o  = (plane_i >> shift_i) & left_mask;
        right_o = (plane_i << keep) & zone_mask & ~left_mask;
        if (kill_i) begin
            left_o  = '0;
            right_o = '0;
        end
    end

endmodule

// File: rtl/qsn_cyclic_shift_pipe.sv
// Two-stage QSN cyclic shifter with valid/ready flow control: stage 1 registers
// the per-plane left/right parts, stage 2 registers their OR-merge.
module qsn_cyclic_shift_pipe
    import qsn_pkg::*;
#(
    parameter int Z_MAX = QSN_Z_MAX,
    parameter int Q     = QSN_Q,
    parameter int SW    = QSN_SW,
    parameter int TAG_W = QSN_TAG_W
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q*Z_MAX-1:0] in_data,
    input  logic [SW-1:0]      in_shift,
    input  logic [SW-1:0]      in_zlen,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q*Z_MAX-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    logic               err_d;
    logic [SW-1:0]      shift_d;
    logic [Q*Z_MAX-1:0] left_d;
    logic [Q*Z_MAX-1:0] right_d;

    logic               s1_v_q;
    logic [Q*Z_MAX-1:0] s1_left_q;
    logic [Q*Z_MAX-1:0] s1_right_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic               s1_err_q;

    logic               s2_v_q;
    logic [Q*Z_MAX-1:0] out_data_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               out_err_q;

    logic               s1_en;
    logic               s2_en;

    // Inverse rotation by s is forward rotation by (z - s) mod z.
    always_comb begin
        err_d   = (in_zlen == '0) || (int'(in_zlen) > Z_MAX) || (in_shift >= in_zlen);
        shift_d = in_shift;
        if (in_inv && (in_shift != '0)) begin
            shift_d = in_zlen - in_shift;
        end
    end

    for (genvar b = 0; b < Q; b++) begin : g_plane
        qsn_rot_plane #(
            .Z_MAX (Z_MAX),
            .SW    (SW)
        ) u_rot (
            .plane_i (in_data[plane_idx(b, Z_MAX) +: Z_MAX]),
            .shift_i (shift_d),
            .zlen_i  (in_zlen),
            .kill_i  (err_d),
            .left_o  (left_d[plane_idx(b, Z_MAX) +: Z_MAX]),
            .right_o (right_d[plane_idx(b, Z_MAX) +: Z_MAX])
        );
    end

    assign s2_en    = !s2_v_q || out_ready;
    assign s1_en    = !s1_v_q || s2_en;
    assign in_ready = s1_en;

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            // NOTE: data registers are cleared as well so an X can never
            // reach out_data, even right after reset.
            s1_v_q     <= 1'b0;
            s1_left_q  <= '0;
            s1_right_q <= '0;
            s1_tag_q   <= '0;
            s1_err_q   <= 1'b0;
            s2_v_q     <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            out_err_q  <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_v_q <= in_valid;
                if (in_valid) begin
                    s1_left_q  <= left_d;
                    s1_right_q <= right_d;
                    s1_tag_q   <= in_tag;
                    s1_err_q   <= err_d;
                end
            end
            if (s2_en) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    out_data_q <= s1_left_q | s1_right_q;
                    out_tag_q  <= s1_tag_q;
                    out_err_q  <= s1_err_q;
                end
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_qsn_cyclic_shift_pipe.sv
// Self-checking bench for qsn_cyclic_shift_pipe: directed and random beats
// compared against a column-by-column modular rotation model.
module tb_qsn_cyclic_shift_pipe;

    localparam int Z  = 15;
    localparam int Q  = 4;
    localparam int SW = 4;
    localparam int TW = 8;
    localparam int DW = Q * Z;

    logic          sys_clk   = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data   = '0;
    logic [SW-1:0] in_shift  = '0;
    logic [SW-1:0] in_zlen   = '0;
    logic          in_inv    = 1'b0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          out_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;

    qsn_cyclic_shift_pipe dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_zlen   (in_zlen),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // out[b][j] = in[b][(j + s_e) mod z] for j < z, zero elsewhere.
    function automatic exp_t model(input logic [DW-1:0] d, input int s, input int z,
                                   input bit inv, input logic [TW-1:0] tag);
        exp_t e;
        int   se;
        e.data = '0;
        e.tag  = tag;
        e.err  = (z == 0) || (z > Z) || (s >= z);
        if (!e.err) begin
            se = inv ? (z - s) % z : s;
            for (int b = 0; b < Q; b++) begin
                for (int j = 0; j < z; j++) begin
                    e.data[b*Z + j] = d[b*Z + (j + se) % z];
                end
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [DW-1:0] d, input logic [TW-1:0] tag, input logic err);
        exp_t e;
        e.data = d;
        e.tag  = tag;
        e.err  = err;
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic drive(input logic [DW-1:0] d, input int s, input int z, input bit inv,
                         input logic [TW-1:0] tag, input exp_t e);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = SW'(s);
        in_zlen  = SW'(z);
        in_inv   = inv;
        in_tag   = tag;
        cur_exp  = e;
    endtask

    // One clock: score any output transfer, record any input transfer, advance.
    task automatic cycle(output bit acc);
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("sb_data", 64'(out_data), 64'(e.data));
                check("sb_tag", 64'(out_tag), 64'(e.tag));
                check("sb_err", 64'(out_err), 64'(e.err));
            end
        end
        if (acc) sb.push_back(cur_exp);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input int s, input int z, input bit inv,
                        input logic [TW-1:0] tag, input exp_t e);
        bit acc;
        acc = 1'b0;
        drive(d, s, z, inv, tag, e);
        for (int n = 0; n < 20 && !acc; n++) cycle(acc);
        check("accept_timeout", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        for (int n = 0; n < 60 && sb.size() != 0; n++) cycle(acc);
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        bit            acc;
        logic [DW-1:0] r;
        logic [DW-1:0] f;
        logic [DW-1:0] m7;
        logic [DW-1:0] bd[20];
        int            bs[20];
        int            bz[20];
        bit            bi[20];
        int            idx;
        int            z;
        int            s;
        bit            inv;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // z=15, s=3 forward, single column, two-cycle latency
        drive(60'h1, 3, 15, 1'b0, 8'hA5, mk(60'h1000, 8'hA5, 1'b0));
        cycle(acc);
        check("t1_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
        check("t1_lat1_valid", 64'(out_valid), 64'(0));
        cycle(acc);
        check("t1_lat2_valid", 64'(out_valid), 64'(1));
        check("t1_data", 64'(out_data), 64'(60'h1000));
        check("t1_tag", 64'(out_tag), 64'(8'hA5));
        drain();

        // z=7, s=2: cols 0,2 -> 5,0; columns 7..14 are forced to zero
        send({15'h7F05, 15'h0, 15'h0, 15'h7F05}, 2, 7, 1'b0, 8'h11,
             mk({15'h21, 15'h0, 15'h0, 15'h21}, 8'h11, 1'b0));
        drain();

        // Round trips and identity
        r = rand_data();
        f = model(r, 11, 15, 1'b0, 8'h20).data;
        send(r, 11, 15, 1'b0, 8'h20, mk(f, 8'h20, 1'b0));
        send(f, 11, 15, 1'b1, 8'h21, mk(r, 8'h21, 1'b0));
        r = rand_data();
        send(r, 0, 15, 1'b0, 8'h22, mk(r, 8'h22, 1'b0));
        send(r, 0, 15, 1'b1, 8'h23, mk(r, 8'h23, 1'b0));
        r  = rand_data();
        m7 = {15'h7F, 15'h7F, 15'h7F, 15'h7F};
        f  = model(r, 3, 7, 1'b0, 8'h24).data;
        send(r, 3, 7, 1'b0, 8'h24, mk(f, 8'h24, 1'b0));
        send(f, 3, 7, 1'b1, 8'h25, mk(r & m7, 8'h25, 1'b0));
        drain();

        // Illegal parameters, then a clean beat right after
        r = rand_data();
        send(r, 9, 8, 1'b0, 8'h3C, mk('0, 8'h3C, 1'b1));
        send(r, 1, 8, 1'b0, 8'h3D, model(r, 1, 8, 1'b0, 8'h3D));
        send(r, 0, 0, 1'b0, 8'h3E, mk('0, 8'h3E, 1'b1));
        send(r, 15, 15, 1'b1, 8'h3F, mk('0, 8'h3F, 1'b1));
        send(r, 14, 15, 1'b0, 8'h40, model(r, 14, 15, 1'b0, 8'h40));
        send(r, 1, 1, 1'b0, 8'h41, mk('0, 8'h41, 1'b1));
        send(r, 0, 1, 1'b1, 8'h42, model(r, 0, 1, 1'b1, 8'h42));
        drain();

        // 20 back-to-back beats, downstream stalls for cycles 4..7
        for (int i = 0; i < 20; i++) begin
            bd[i] = rand_data();
            bz[i] = $urandom_range(1, 15);
            bs[i] = $urandom_range(0, bz[i] - 1);
            bi[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int k = 0; k < 100 && idx < 20; k++) begin
            out_ready = !(k >= 4 && k <= 7);
            drive(bd[idx], bs[idx], bz[idx], bi[idx], 8'(idx),
                  model(bd[idx], bs[idx], bz[idx], bi[idx], 8'(idx)));
            #1;
            if (k >= 5 && k <= 7) check($sformatf("bp_in_ready_k%0d", k), 64'(in_ready), 64'(0));
            cycle(acc);
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_sent", 64'(idx), 64'(20));
        drain();

        // Reset with two beats in flight
        r = rand_data();
        drive(r, 2, 9, 1'b0, 8'h77, model(r, 2, 9, 1'b0, 8'h77));
        cycle(acc);
        drive(r, 5, 12, 1'b1, 8'h78, model(r, 5, 12, 1'b1, 8'h78));
        cycle(acc);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge sys_clk);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_out_data", 64'(out_data), 64'(0));
        sb.delete();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle(acc);
            check("mid_rst_no_stale", 64'(out_valid), 64'(0));
        end
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));

        // Random mixed z / s / direction with random backpressure
        idx = 0;
        z   = $urandom_range(0, 15);
        s   = (z > 0 && $urandom_range(0, 3) != 0) ? $urandom_range(0, z - 1) : $urandom_range(0, 15);
        inv = 1'($urandom_range(0, 1));
        r   = rand_data();
        for (int k = 0; k < 400 && idx < 40; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(r, s, z, inv, 8'(8'h80 + idx), model(r, s, z, inv, 8'(8'h80 + idx)));
            cycle(acc);
            if (acc) begin
                idx++;
                z   = $urandom_range(0, 15);
                s   = (z > 0 && $urandom_range(0, 3) != 0) ? $urandom_range(0, z - 1) : $urandom_range(0, 15);
                inv = 1'($urandom_range(0, 1));
                r   = rand_data();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_all_sent", 64'(idx), 64'(40));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
